// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data-port responder: word RAM, GPIO registers, prescaled 64-bit machine timer
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   mem_addr_i     byte address from the core MEM stage (bits [1:0] ignored)
//   mem_wr_data_i  merged 32-bit store word
//   mem_wr_sig_i   write strobe, commits at the rising edge where it is high
//   mem_rd_data_o  combinational read data for mem_addr_i (0 while in reset)
//   gpio_i         asynchronous input pins
//   gpio_o         GPIO output register
//   timer_irq_o    registered timer interrupt level (mtime >= mtimecmp)

module data_bus_responder #(
    parameter int RAM_WORDS = 1024,
    parameter int GPIO_W    = 8,
    parameter int TICK_DIV  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wr_data_i,
    input  logic              mem_wr_sig_i,
    output logic [31:0]       mem_rd_data_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              timer_irq_o
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [31:0] ADDR_GPIO_OUT    = 32'h8000_0000;
    localparam logic [31:0] ADDR_GPIO_IN     = 32'h8000_0004;
    localparam logic [31:0] ADDR_MTIME_LO    = 32'h8000_0008;
    localparam logic [31:0] ADDR_MTIME_HI    = 32'h8000_000C;
    localparam logic [31:0] ADDR_MTIMECMP_LO = 32'h8000_0010;
    localparam logic [31:0] ADDR_MTIMECMP_HI = 32'h8000_0014;

    // State
    logic [31:0]       ram_q [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_out_q,  gpio_out_d;
    logic [GPIO_W-1:0] gpio_meta_q, gpio_meta_d;
    logic [GPIO_W-1:0] gpio_sync_q, gpio_sync_d;
    logic [PW-1:0]     presc_q,     presc_d;
    logic [63:0]       mtime_q,     mtime_d;
    logic [63:0]       mtimecmp_q,  mtimecmp_d;
    logic              irq_q,       irq_d;

    // Decode
    logic [31:0]   a;
    logic [AW-1:0] ram_idx;
    logic          sel_ram;
    logic          ram_we;
    logic          tick;

    always_comb begin
        // Masking keeps every address bit referenced while ignoring [1:0].
        a       = mem_addr_i & 32'hFFFF_FFFC;
        ram_idx = a[AW+1:2];
        sel_ram = (a[31:AW+2] == '0);
        ram_we  = mem_wr_sig_i && sel_ram && !reset;
        tick    = (presc_q == PRESC_MAX);
    end

    // Read mux: sees only pre-edge register values, so a same-cycle
    // read of a location being written returns the old contents.
    always_comb begin
        mem_rd_data_o = 32'h0000_0000;
        if (!reset) begin
            if (sel_ram) begin
                mem_rd_data_o = ram_q[ram_idx];
            end else begin
                case (a)
                    ADDR_GPIO_OUT:    mem_rd_data_o = 32'(gpio_out_q);
                    ADDR_GPIO_IN:     mem_rd_data_o = 32'(gpio_sync_q);
                    ADDR_MTIME_LO:    mem_rd_data_o = mtime_q[31:0];
                    ADDR_MTIME_HI:    mem_rd_data_o = mtime_q[63:32];
                    ADDR_MTIMECMP_LO: mem_rd_data_o = mtimecmp_q[31:0];
                    ADDR_MTIMECMP_HI: mem_rd_data_o = mtimecmp_q[63:32];
                    default:          mem_rd_data_o = 32'h0000_0000;
                endcase
            end
        end
    end

    // Next-state
    always_comb begin
        gpio_out_d  = gpio_out_q;
        gpio_meta_d = gpio_i;
        gpio_sync_d = gpio_meta_q;
        presc_d     = tick ? '0 : presc_q + PW'(1);
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        irq_d       = (mtime_q >= mtimecmp_q);

        if (mem_wr_sig_i && !sel_ram) begin
            case (a)
                ADDR_GPIO_OUT:    gpio_out_d = mem_wr_data_i[GPIO_W-1:0];
                // A CPU write to either mtime half overrides that cycle's increment.
                ADDR_MTIME_LO:    mtime_d    = {mtime_q[63:32], mem_wr_data_i};
                ADDR_MTIME_HI:    mtime_d    = {mem_wr_data_i, mtime_q[31:0]};
                ADDR_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], mem_wr_data_i};
                ADDR_MTIMECMP_HI: mtimecmp_d = {mem_wr_data_i, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    // RAM contents are deliberately not reset; writes during reset are blocked via ram_we.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_q  <= '0;
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
            presc_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            irq_q       <= 1'b0;
        end else begin
            gpio_out_q  <= gpio_out_d;
            gpio_meta_q <= gpio_meta_d;
            gpio_sync_q <= gpio_sync_d;
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            irq_q       <= irq_d;
        end
    end

    assign gpio_o      = gpio_out_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - directed self-checking bench for data_bus_responder

module tb_data_bus_responder;

    localparam logic [31:0] GPIO_OUT    = 32'h8000_0000;
    localparam logic [31:0] GPIO_IN     = 32'h8000_0004;
    localparam logic [31:0] MTIME_LO    = 32'h8000_0008;
    localparam logic [31:0] MTIME_HI    = 32'h8000_000C;
    localparam logic [31:0] MTIMECMP_LO = 32'h8000_0010;
    localparam logic [31:0] MTIMECMP_HI = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset;

    // Instance with TICK_DIV=4
    logic [31:0] addr, wdata;
    logic        we;
    logic [7:0]  pins;
    logic [31:0] rd;
    logic [7:0]  gpio_out;
    logic        irq;

    // Instance with TICK_DIV=1
    logic [31:0] b_addr, b_wdata;
    logic        b_we;
    logic [7:0]  b_pins;
    logic [31:0] b_rd;
    logic [7:0]  b_gpio_out;
    logic        b_irq;

    int tests = 0;
    int fails = 0;
    int edges = 0;
    logic found;

    data_bus_responder #(.RAM_WORDS(1024), .GPIO_W(8), .TICK_DIV(4)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr_i    (addr),
        .mem_wr_data_i (wdata),
        .mem_wr_sig_i  (we),
        .mem_rd_data_o (rd),
        .gpio_i        (pins),
        .gpio_o        (gpio_out),
        .timer_irq_o   (irq)
    );

    data_bus_responder #(.RAM_WORDS(1024), .GPIO_W(8), .TICK_DIV(1)) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .mem_addr_i    (b_addr),
        .mem_wr_data_i (b_wdata),
        .mem_wr_sig_i  (b_we),
        .mem_rd_data_o (b_rd),
        .gpio_i        (b_pins),
        .gpio_o        (b_gpio_out),
        .timer_irq_o   (b_irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] ad, input logic [31:0] exp);
        addr = ad;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic b_rd_chk(input string tag, input logic [31:0] ad, input logic [31:0] exp);
        b_addr = ad;
        #1;
        check(tag, b_rd, exp);
    endtask

    task automatic wr(input logic [31:0] ad, input logic [31:0] d);
        addr  = ad;
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        addr = MTIMECMP_LO; wdata = '0; we = 1'b0; pins = '0;
        b_addr = '0; b_wdata = '0; b_we = 1'b0; b_pins = '0;

        // Reset values
        tick(2);
        check("rst_rd_forced_zero", rd, 32'h0);
        check("rst_gpio_o", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        edges = 0;
        rd_chk("rst_mtimecmp_lo", MTIMECMP_LO, 32'hFFFF_FFFF);
        rd_chk("rst_mtimecmp_hi", MTIMECMP_HI, 32'hFFFF_FFFF);
        rd_chk("rst_mtime_hi", MTIME_HI, 32'h0);
        rd_chk("rst_mtime_lo", MTIME_LO, 32'h0);

        // Timer with TICK_DIV=4: tick edges are 4, 8, 12, ... after release
        tick(3);
        rd_chk("mtime_after3", MTIME_LO, 32'd0);
        tick(1);
        rd_chk("mtime_after4", MTIME_LO, 32'd1);
        tick(16);
        rd_chk("mtime_after20", MTIME_LO, 32'd5);

        // Carry from LO into HI (writes at edges 21, 22; tick at 24)
        wr(MTIME_LO, 32'hFFFF_FFFF);
        wr(MTIME_HI, 32'h0);
        rd_chk("mtime_lo_written", MTIME_LO, 32'hFFFF_FFFF);
        rd_chk("mtime_hi_written", MTIME_HI, 32'h0);
        tick(4);
        rd_chk("carry_lo", MTIME_LO, 32'h0);
        rd_chk("carry_hi", MTIME_HI, 32'h1);

        // Write collides with the tick at edge 28
        tick(1);
        wr(MTIME_LO, 32'h100);
        check("edge_count_collision", 32'(edges), 32'd28);
        rd_chk("collide_lo", MTIME_LO, 32'h100);
        rd_chk("collide_hi_hold", MTIME_HI, 32'h1);
        tick(3);
        rd_chk("collide_before_next", MTIME_LO, 32'h100);
        tick(1);
        rd_chk("collide_next_tick", MTIME_LO, 32'h101);

        // RAM write/read and read-during-write
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        wdata = 32'h1234_5678;
        we    = 1'b1;
        #1;
        check("ram_rd_during_wr", rd, 32'hDEAD_BEEF);
        tick(1);
        we = 1'b0;
        rd_chk("ram_rd_after_wr", 32'h0000_0010, 32'h1234_5678);
        rd_chk("ram_low_bits_ignored", 32'h0000_0013, 32'h1234_5678);
        wr(32'h0000_0FFC, 32'hA5A5_0FFC);
        rd_chk("ram_last_word", 32'h0000_0FFC, 32'hA5A5_0FFC);
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_1000, 32'h2222_2222);
        rd_chk("ram_no_alias", 32'h0000_0000, 32'h1111_1111);
        rd_chk("above_ram_reads_zero", 32'h0000_1000, 32'h0);

        // Unmapped access
        wr(32'h8000_0020, 32'h55);
        rd_chk("unmapped_rd", 32'h8000_0020, 32'h0);
        rd_chk("unmapped_rd_0x18", 32'h8000_0018, 32'h0);
        check("unmapped_gpio_o", 32'(gpio_out), 32'h0);
        rd_chk("unmapped_cmp_lo", MTIMECMP_LO, 32'hFFFF_FFFF);
        rd_chk("unmapped_ram", 32'h0000_0010, 32'h1234_5678);

        // GPIO
        wr(GPIO_OUT, 32'h1A5);
        check("gpio_o_trunc", 32'(gpio_out), 32'hA5);
        rd_chk("gpio_out_rd", GPIO_OUT, 32'hA5);
        wr(GPIO_IN, 32'hFF);
        rd_chk("gpio_in_ro", GPIO_IN, 32'h0);
        pins = 8'h3C;
        tick(1);
        rd_chk("gpio_in_edge1", GPIO_IN, 32'h0);
        tick(1);
        rd_chk("gpio_in_edge2", GPIO_IN, 32'h3C);

        // Interrupt on the TICK_DIV=1 instance
        b_addr = MTIME_LO; b_wdata = 32'h0; b_we = 1'b1;
        tick(1);
        b_addr = MTIMECMP_HI; b_wdata = 32'h0;
        tick(1);
        b_addr = MTIMECMP_LO; b_wdata = 32'd10;
        tick(1);
        b_we = 1'b0;
        check("irq_low_start", 32'(b_irq), 32'h0);
        b_rd_chk("b_mtime_2", MTIME_LO, 32'd2);
        b_rd_chk("b_cmp_hi", MTIMECMP_HI, 32'h0);
        b_addr = MTIME_LO;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (b_rd == 32'd10) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("irq_mtime_reached_10", 32'(found), 32'h1);
        check("irq_low_at_10", 32'(b_irq), 32'h0);
        tick(1);
        check("irq_rise", 32'(b_irq), 32'h1);
        b_rd_chk("b_mtime_11", MTIME_LO, 32'd11);
        b_addr = MTIMECMP_LO; b_wdata = 32'hFFFF_FFFF; b_we = 1'b1;
        tick(1);
        b_we = 1'b0;
        check("irq_hold_at_commit", 32'(b_irq), 32'h1);
        tick(1);
        check("irq_fall", 32'(b_irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-side responder for the pipelined core's data port: it receives `mem_addr` / `mem_wr_data` / `mem_wr_sig` from the core's MEM stage and returns `mem_rd_data` in the same cycle. It contains three things:
- a word-addressed data RAM;
- a GPIO output/input register pair;
- a 64-bit prescaled machine timer with compare and a registered interrupt.

It sits at the top level beside the core, opposite the core's data master port.

## Interface
Parameters:
- `RAM_WORDS`, 1024, number of 32-bit RAM words; power of two, 16..65536.
- `GPIO_W`, 8, GPIO width; 1..32.
- `TICK_DIV`, 4, clock cycles per mtime increment; ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr_i`  in  32  byte address from core MEM stage; bits [1:0] ignored.
- `mem_wr_data_i`  in  32  full merged store word from core.
- `mem_wr_sig_i`  in  1  write strobe; a write commits at the rising edge where it is high.
- `mem_rd_data_o`  out  32  read data, combinational from `mem_addr_i`.
- `gpio_i`  in  GPIO_W  asynchronous input pins.
- `gpio_o`  out  GPIO_W  output register.
- `timer_irq_o`  out  1  registered timer interrupt level.

Reset and clocking (already decided): one clock; reset is synchronous and active-high.

## Operation
Address map, full 32-bit decode; `a` = `mem_addr_i` with [1:0] cleared.

RAM region:
- `0x0000_0000`..`RAM_WORDS*4-1`: RAM, read/write.
- Index is `a[log2(RAM_WORDS)+1:2]`.

Peripheral registers:
- `0x8000_0000` GPIO_OUT, R/W.
  - Low `GPIO_W` bits are stored.
  - Reads zero-extend.
- `0x8000_0004` GPIO_IN, read-only.
  - Returns the synchroniser output, zero-extended.
  - Writes are ignored.
- `0x8000_0008` MTIME_LO, R/W.
- `0x8000_000C` MTIME_HI, R/W.
- `0x8000_0010` MTIMECMP_LO, R/W.
- `0x8000_0014` MTIMECMP_HI, R/W.

Any other address:
- Reads return `0x0000_0000`.
- Writes are ignored; no other side effect.

Read path:
- Purely combinational.
- Same-cycle read of an address being written returns the pre-write value.
- `mem_rd_data_o` is forced to 0 while `reset` is high.

Write path:
- Only one target updates per cycle.
- Byte/half stores are the core's responsibility; this block is word-granular.

Timer:
- Prescaler counts 0..TICK_DIV-1 and wraps to 0.
- On the wrap cycle, mtime increments by 1; the 64-bit value wraps to 0 after all-ones.
- With TICK_DIV=1, mtime increments every cycle.
- CPU write to MTIME_LO/HI on a tick cycle:
  - the written half takes the written value;
  - the other half holds;
  - no increment or carry occurs that cycle.
- Prescaler is unaffected by CPU writes.

Interrupt:
- `timer_irq_o` <= (mtime >= mtimecmp), unsigned 64-bit compare.
- Uses register values before the edge, so `timer_irq_o` lags the registers by one cycle.
- Level-sensitive; cleared only by raising mtimecmp or lowering mtime.

GPIO_IN:
- Two-flop synchroniser on `gpio_i`.

## Timing
Reset (synchronous, takes effect at the first edge with `reset` high):
- `gpio_o`=0, GPIO_IN sync flops=0, mtime=0, prescaler=0.
- mtimecmp=`0xFFFF_FFFF_FFFF_FFFF`.
- `timer_irq_o`=0.
- RAM contents are not reset.
- Writes presented in a reset cycle are discarded, RAM included.

Reset released mid-count: the prescaler restarts from 0 on the first non-reset edge.

Latencies:
- Read latency: 0 cycles (combinational).
- Write: visible on `mem_rd_data_o` in the cycle after the committing edge.
- `gpio_o` updates at the committing edge.
- A pin change is visible in GPIO_IN two edges after it is sampled.
- After mtime reaches mtimecmp, `timer_irq_o` rises one edge later.

## Test plan
1. **Reset values:** hold `reset` 2 cycles -> `gpio_o`=0, `timer_irq_o`=0, MTIMECMP_LO/HI read `0xFFFF_FFFF`, MTIME reads 0, `mem_rd_data_o`=0 during reset.
2. **RAM write/read and read-during-write:**
   - write `0xDEADBEEF` to `0x0000_0010`, then read -> `0xDEADBEEF`;
   - same-cycle read of `0x0000_0010` while writing `0x1234_5678` -> `0xDEADBEEF`;
   - next cycle -> `0x1234_5678`.
3. **Unmapped access and GPIO:**
   - write `0x55` to `0x8000_0020` -> no register changes, read returns 0;
   - write `0x1A5` to GPIO_OUT with GPIO_W=8 -> `gpio_o`=`0xA5`;
   - drive `gpio_i`=`0x3C` -> GPIO_IN reads `0x3C` from the second edge after sampling.
4. **Timer with TICK_DIV=4:**
   - after reset release, MTIME_LO reads 1 after 4 edges and 5 after 20;
   - write MTIME_LO=`0xFFFF_FFFF`, MTIME_HI=0, then after 4 edges MTIME_HI=1 and MTIME_LO=0.
5. **Write-vs-tick collision:** write MTIME_LO=`0x100` on a tick edge -> MTIME_LO reads `0x100`, not `0x101`; next tick -> `0x101`.
6. **Interrupt:**
   - set MTIMECMP_HI=0, MTIMECMP_LO=10 with TICK_DIV=1 -> `timer_irq_o` rises exactly one edge after mtime reads 10;
   - write MTIMECMP_LO=`0xFFFF_FFFF` -> falls one edge after the write commits.
